// File: rtl/apb_mem_target.sv
// apb_mem_target: APB completer backed by a byte-strobed word memory with
// programmable wait states, protocol-violation flag and completion counter.
module apb_mem_target #(
    parameter int APB_DW      = 32,
    parameter int APB_AW      = 12,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic [APB_AW-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_DW-1:0] pwdata,
    input  logic [APB_DW/8-1:0] pstrb,
    output logic [APB_DW-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              prot_err_clr,
    output logic              prot_err,
    output logic [15:0]       xfer_cnt
);
    localparam int NB = APB_DW / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = APB_AW - LB;
    localparam int MW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state, state_nxt;
    logic [APB_AW-1:0]   addr_q;
    logic                write_q;
    logic [APB_DW-1:0]   wdata_q;
    logic [NB-1:0]       strb_q;
    logic [3:0]          wait_cnt;
    logic [APB_DW-1:0]   mem [DEPTH];
    logic [IW-1:0]       widx;
    logic                addr_err, busy, in_access, done, idle_bad, viol, good, setup_hit;

    assign widx      = addr_q[APB_AW-1:LB];
    assign addr_err  = (32'(widx) >= 32'(DEPTH)) || (addr_q[LB-1:0] != '0);
    assign busy      = state != IDLE;
    assign setup_hit = !busy && psel && !penable;
    // SETUP state is the first access cycle, so it completes just like ACCESS
    assign in_access = busy && psel && penable;
    assign done      = in_access && wait_cnt == 4'd0;
    assign idle_bad  = !busy && psel && penable;
    assign viol      = busy && !(psel && penable);
    assign good      = done && !addr_err;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = !busy ? (setup_hit ? SETUP : IDLE) : (!in_access || done) ? IDLE : ACCESS;
    end

    always_comb begin
        pready  = done || idle_bad;
        pslverr = idle_bad || (done && addr_err);
        prdata  = (good && !write_q) ? mem[widx[MW-1:0]] : '0;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            wait_cnt <= '0;
        end else if (setup_hit) begin
            addr_q   <= paddr;
            write_q  <= pwrite;
            wdata_q  <= pwdata;
            strb_q   <= pstrb;
            wait_cnt <= 4'(WAIT_CYCLES);
        end else if (in_access && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (good && write_q) begin
            for (int b = 0; b < NB; b++)
                if (strb_q[b]) mem[widx[MW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            prot_err <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            prot_err <= (idle_bad || viol) ? 1'b1 : prot_err_clr ? 1'b0 : prot_err;
            xfer_cnt <= good ? xfer_cnt + 16'd1 : xfer_cnt;
        end
    end
endmodule

// File: tb/tb_apb_mem_target.sv
// tb_apb_mem_target: directed checks of apb_mem_target with one and zero wait states.
module tb_apb_mem_target;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] paddr = '0;
    logic        psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0, clr = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b, perr_a, perr_b;
    logic [15:0] cnt_a, cnt_b;
    logic        tgt = 1'b0;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] rd;
    logic        er;
    int          cyc;

    always #5 clk = ~clk;

    apb_mem_target #(.APB_DW(32), .APB_AW(12), .DEPTH(64), .WAIT_CYCLES(1)) dut_a (
        .pclk(clk), .preset_n(rst_n), .paddr(paddr), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a), .pready(pready_a),
        .pslverr(pslverr_a), .prot_err_clr(clr), .prot_err(perr_a), .xfer_cnt(cnt_a));

    apb_mem_target #(.APB_DW(32), .APB_AW(12), .DEPTH(64), .WAIT_CYCLES(0)) dut_b (
        .pclk(clk), .preset_n(rst_n), .paddr(paddr), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_b), .pready(pready_b),
        .pslverr(pslverr_b), .prot_err_clr(clr), .prot_err(perr_b), .xfer_cnt(cnt_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sel(input logic v);
        psel_a = tgt ? 1'b0 : v;
        psel_b = tgt ? v : 1'b0;
    endtask

    task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] r, output logic e, output int c);
        @(posedge clk); #1;
        sel(1'b1); penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        c = 0;
        forever begin
            c++;
            @(negedge clk);
            if (tgt ? pready_b : pready_a) break;
            if (c > 20) begin
                chk("timeout", 32'(c), 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        r = tgt ? prdata_b : prdata_a;
        e = tgt ? pslverr_b : pslverr_a;
        @(posedge clk); #1;
        sel(1'b0); penable = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_b [4];
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_prdata", prdata_a, 32'd0);
        chk("rst_pready", {31'd0, pready_a}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr_a}, 32'd0);
        chk("rst_prot_err", {31'd0, perr_a}, 32'd0);
        chk("rst_cnt", {16'd0, cnt_a}, 32'd0);

        xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, er, cyc);
        chk("wr_cycles", 32'(cyc), 32'd2);
        chk("wr_err", {31'd0, er}, 32'd0);
        xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, er, cyc);
        chk("rd_cycles", 32'(cyc), 32'd2);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", {31'd0, er}, 32'd0);
        chk("cnt_2", {16'd0, cnt_a}, 32'd2);
        @(negedge clk);
        chk("prdata_idle", prdata_a, 32'd0);

        xfer(1'b1, 12'h010, 32'h11223344, 4'h5, rd, er, cyc);
        xfer(1'b0, 12'h010, 32'h0, 4'hF, rd, er, cyc);
        chk("strb_merge", rd, 32'hDE22BE44);

        xfer(1'b0, 12'h100, 32'h0, 4'h0, rd, er, cyc);
        chk("oob_err", {31'd0, er}, 32'd1);
        chk("oob_data", rd, 32'd0);
        chk("oob_cycles", 32'(cyc), 32'd2);
        xfer(1'b0, 12'h002, 32'h0, 4'h0, rd, er, cyc);
        chk("mis_err", {31'd0, er}, 32'd1);
        chk("mis_data", rd, 32'd0);
        xfer(1'b1, 12'h012, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
        chk("mis_wr_err", {31'd0, er}, 32'd1);
        chk("cnt_err", {16'd0, cnt_a}, 32'd4);
        xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, er, cyc);
        chk("mem_kept", rd, 32'hDE22BE44);

        xfer(1'b1, 12'h010, 32'h0, 4'h0, rd, er, cyc);
        chk("nostrb_err", {31'd0, er}, 32'd0);
        chk("nostrb_cnt", {16'd0, cnt_a}, 32'd6);
        xfer(1'b1, 12'h0FC, 32'hCAFEF00D, 4'hF, rd, er, cyc);
        xfer(1'b0, 12'h0FC, 32'h0, 4'h0, rd, er, cyc);
        chk("last_word", rd, 32'hCAFEF00D);
        xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, er, cyc);
        chk("nostrb_kept", rd, 32'hDE22BE44);
        chk("cnt_9", {16'd0, cnt_a}, 32'd9);

        // captured address/data must win over bus changes during access
        @(posedge clk); #1;
        psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'h01020304; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1; paddr = 12'h018; pwdata = 32'hBADBAD00; pwrite = 1'b0; pstrb = 4'h0;
        @(negedge clk); @(negedge clk);
        chk("chg_pready", {31'd0, pready_a}, 32'd1);
        @(posedge clk); #1;
        psel_a = 1'b0; penable = 1'b0;
        xfer(1'b0, 12'h014, 32'h0, 4'h0, rd, er, cyc);
        chk("chg_data", rd, 32'h01020304);
        xfer(1'b0, 12'h018, 32'h0, 4'h0, rd, er, cyc);
        chk("chg_other", rd, 32'd0);

        @(posedge clk); #1;
        psel_a = 1'b1; penable = 1'b1;
        @(negedge clk);
        chk("idle_pready", {31'd0, pready_a}, 32'd1);
        chk("idle_pslverr", {31'd0, pslverr_a}, 32'd1);
        @(posedge clk); #1;
        psel_a = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("idle_prot_err", {31'd0, perr_a}, 32'd1);
        @(posedge clk); #1;
        psel_a = 1'b1; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h0; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel_a = 1'b0; penable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_prot_err", {31'd0, perr_a}, 32'd1);
        chk("abort_cnt", {16'd0, cnt_a}, 32'd12);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_prot_err", {31'd0, perr_a}, 32'd0);
        xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, er, cyc);
        chk("abort_mem", rd, 32'hDE22BE44);
        @(posedge clk); #1;
        psel_a = 1'b1; penable = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        psel_a = 1'b0; penable = 1'b0; clr = 1'b0;
        chk("set_wins", {31'd0, perr_a}, 32'd1);

        @(posedge clk); #1;
        psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020; pwdata = 32'h55555555; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b0; psel_a = 1'b0; penable = 1'b0;
        #1;
        chk("mid_rst_prdata", prdata_a, 32'd0);
        chk("mid_rst_pready", {31'd0, pready_a}, 32'd0);
        chk("mid_rst_prot_err", {31'd0, perr_a}, 32'd0);
        chk("mid_rst_cnt", {16'd0, cnt_a}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(1'b0, 12'h020, 32'h0, 4'h0, rd, er, cyc);
        chk("mid_rst_mem", rd, 32'd0);
        chk("mid_rst_cycles", 32'(cyc), 32'd2);
        chk("post_rst_cnt", {16'd0, cnt_a}, 32'd1);

        tgt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b[i] = 32'hA5000000 + 32'(i * 17);
            xfer(1'b1, 12'(i * 4), exp_b[i], 4'hF, rd, er, cyc);
        end
        chk("b_wr_cycles", 32'(cyc), 32'd1);
        @(posedge clk); #1;
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                chk("b2b_setup_pready", {31'd0, pready_b}, 32'd0);
            end
            @(posedge clk); #1;
            penable = 1'b1;
            @(negedge clk);
            chk("b2b_pready", {31'd0, pready_b}, 32'd1);
            chk("b2b_data", prdata_b, exp_b[i]);
            @(posedge clk); #1;
            penable = 1'b0;
            if (i < 3) paddr = 12'((i + 1) * 4);
            else psel_b = 1'b0;
        end
        @(negedge clk);
        chk("b2b_cnt", {16'd0, cnt_b}, 32'd8);
        chk("b2b_prot_err", {31'd0, perr_b}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_mem_target.md
APB_MEM_TARGET -- requirements
Module: apb_mem_target

Interface
REQ-001 SHALL have parameter APB_DW, default 32, data width in bits; legal values are 16 and 32.
REQ-002 SHALL have parameter APB_AW, default 12, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, number of APB_DW-wide memory words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, number of access-phase wait states (0..15).
REQ-005 pclk  in  1  sole clock; all logic rises on posedge.
REQ-006 preset_n  in  1  reset, asynchronous, active-low.
REQ-007 paddr  in  APB_AW  byte address, sampled in setup phase.
REQ-008 psel  in  1  completer select.
REQ-009 penable  in  1  access phase indicator.
REQ-010 pwrite  in  1  1 = write, 0 = read.
REQ-011 pwdata  in  APB_DW  write data.
REQ-012 pstrb  in  APB_DW/8  write byte strobes.
REQ-013 prdata  out  APB_DW  read data.
REQ-014 pready  out  1  transfer completion.
REQ-015 pslverr  out  1  transfer error, valid only with pready.
REQ-016 prot_err_clr  in  1  clears prot_err.
REQ-017 prot_err  out  1  sticky protocol-violation flag.
REQ-018 xfer_cnt  out  16  count of error-free completed transfers.

Function
REQ-019 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-020 IDLE -> SETUP when psel=1 and penable=0; at this transition SHALL capture paddr, pwrite, pwdata, pstrb and load the wait counter with WAIT_CYCLES.
REQ-021 SETUP -> ACCESS when psel=1 and penable=1; SETUP -> IDLE with prot_err set if psel=1 and penable=0, or if psel=0.
REQ-022 In ACCESS, pready SHALL be 1 exactly when the wait counter equals 0; the counter SHALL decrement once per ACCESS cycle while it is nonzero.
REQ-023 Transfer latency: pready SHALL rise on the (WAIT_CYCLES+1)-th cycle with penable=1.
REQ-024 On the ACCESS cycle with pready=1, the FSM SHALL go to SETUP if the next cycle presents psel=1 and penable=0 (back-to-back), else to IDLE.
REQ-025 Word index SHALL be paddr[APB_AW-1:log2(APB_DW/8)].
REQ-026 An address SHALL be erroneous if the word index is >= DEPTH or paddr[log2(APB_DW/8)-1:0] != 0.
REQ-027 An erroneous transfer SHALL complete with the same wait states, with pslverr=1, no memory update, prdata=0, and no xfer_cnt increment.
REQ-028 A write SHALL update only the byte lanes with pstrb=1, in the pready cycle; pstrb=0 for all lanes SHALL be a legal no-op write that still counts.
REQ-029 A read SHALL ignore pstrb; prdata SHALL equal the addressed word during the pready cycle and 0 in all other cycles.
REQ-030 A write followed by a read of the same word SHALL return the new data with no extra latency.
REQ-031 If psel falls during ACCESS before pready, the FSM SHALL abort to IDLE with no memory write and no count, and SHALL set prot_err.
REQ-032 If psel=1 and penable=1 in IDLE, the block SHALL respond combinationally with pready=1 and pslverr=1, make no memory change, and set prot_err.
REQ-033 Changes of paddr, pwrite, pwdata or pstrb during ACCESS SHALL be ignored; the captured values are used.
REQ-034 prot_err SHALL stay set until prot_err_clr=1; if set and clear occur in the same cycle, set SHALL win.
REQ-035 xfer_cnt SHALL increment by 1 per error-free completion and wrap from 0xFFFF to 0x0000.
REQ-036 pready and pslverr SHALL be 0 whenever no completion occurs.

Reset
REQ-037 preset_n=0 SHALL force IDLE, wait counter 0, prdata=0, pready=0, pslverr=0, prot_err=0, xfer_cnt=0, and all memory words 0, asynchronously.
REQ-038 Reset asserted mid-transfer SHALL discard the transfer with no memory write; the first legal setup after release SHALL be accepted.

Verification
REQ-039 WAIT_CYCLES=1: write 0xDEADBEEF to 0x010 with pstrb=0xF, then read 0x010 -> pready on 2nd access cycle, prdata=0xDEADBEEF, pslverr=0, xfer_cnt=2.
REQ-040 Word 0x010 holds 0xDEADBEEF; write 0x11223344 with pstrb=0x5, then read -> 0xDE22BE44.
REQ-041 Read 0x100 (index 64) and read 0x002 (misaligned) -> pready with pslverr=1, prdata=0, memory unchanged, xfer_cnt unchanged.
REQ-042 WAIT_CYCLES=0: four back-to-back reads with no IDLE between them -> each completes in 2 cycles, with no dropped or duplicated transfer.
REQ-043 psel=1, penable=1 straight from IDLE; then a setup with psel dropped mid-access -> prot_err=1 stays until prot_err_clr pulse, and no memory change.
REQ-044 preset_n pulsed low during the ACCESS wait of a write to 0x020 -> word 0x020 reads 0 after reset, and all outputs are at reset values.
